dac_sweep_sequencer: RTL and testbench

- Sequences a stepped DAC sweep for pixel characterisation runs. It sits between the run-control start bit and the DAC start generator / DAC serial writer.
- On each sweep point it issues one DAC load and waits for the DAC to go idle and settle.
- It then counts a programmed number of pixel-reset trigger frames, flagging each as valid for acquisition, before stepping the code.
- Runs from the 1 MHz system clock; trigger arrives at ~10 kHz.

---
 rtl/dac_sweep_sequencer.sv | 126 ++++++++++++
 tb/tb_dac_sweep_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sweep_sequencer.sv
// dac_sweep_sequencer: steps a DAC code, waits for DAC idle and settle, then counts trigger frames per step
module dac_sweep_sequencer #(
    parameter int CODE_W         = 12,
    parameter int FRAMES_W       = 8,
    parameter int SETTLE_CYCLES  = 20,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic                trigger,
    input  logic [CODE_W-1:0]   cfg_start_code,
    input  logic [CODE_W-1:0]   cfg_stop_code,
    input  logic [CODE_W-1:0]   cfg_step,
    input  logic [FRAMES_W-1:0] cfg_frames,
    input  logic                dac_busy,
    output logic                dac_start,
    output logic [CODE_W-1:0]   dac_code,
    output logic                frame_valid,
    output logic                sweep_busy,
    output logic                sweep_done,
    output logic                error
);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT_DAC, SETTLE, COUNT, NEXT, DONE, ERR} state_t;
    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] T_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t              state;
    logic                t_s1, t_s2, t_s3, trig_edge;
    logic                start_q, start_armed, start_edge;
    logic [CODE_W-1:0]   stop_l, step_l, step_eff;
    logic [FRAMES_W-1:0] frames_l, frames_eff, fcnt;
    logic [CNT_W-1:0]    cnt;
    logic [CODE_W:0]     nxt;

    // start_armed blocks a start that was already high when reset released
    assign start_edge = start & ~start_q & start_armed;
    assign step_eff   = step_l == '0 ? CODE_W'(1) : step_l;
    assign frames_eff = frames_l == '0 ? FRAMES_W'(1) : frames_l;
    assign nxt        = {1'b0, dac_code} + {1'b0, step_eff};
    assign sweep_busy = state != IDLE && state != ERR;

    // trigger synchroniser with registered rising-edge pulse, and start edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_s1        <= 1'b0;
            t_s2        <= 1'b0;
            t_s3        <= 1'b0;
            trig_edge   <= 1'b0;
            start_q     <= 1'b0;
            start_armed <= 1'b0;
        end else begin
            t_s1        <= trigger;
            t_s2        <= t_s1;
            t_s3        <= t_s2;
            trig_edge   <= t_s2 & ~t_s3;
            start_q     <= start;
            start_armed <= start_armed | ~start;
        end
    end

    // sweep state machine; abort overrides every transition
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            dac_start   <= 1'b0;
            dac_code    <= '0;
            frame_valid <= 1'b0;
            sweep_done  <= 1'b0;
            error       <= 1'b0;
            stop_l      <= '0;
            step_l      <= '0;
            frames_l    <= '0;
            fcnt        <= '0;
            cnt         <= '0;
        end else begin
            dac_start   <= 1'b0;
            frame_valid <= 1'b0;
            sweep_done  <= 1'b0;
            if (abort) state <= IDLE;
            else case (state)
                IDLE, ERR: if (start_edge) begin
                    stop_l    <= cfg_stop_code;
                    step_l    <= cfg_step;
                    frames_l  <= cfg_frames;
                    dac_code  <= cfg_start_code;
                    error     <= 1'b0;
                    dac_start <= 1'b1;
                    state     <= LOAD;
                end
                LOAD: begin
                    cnt   <= '0;
                    state <= WAIT_DAC;
                end
                WAIT_DAC: if (cnt != '0 && !dac_busy) begin
                    cnt   <= '0;
                    state <= SETTLE;
                end else if (cnt == T_LAST) begin
                    error <= 1'b1;
                    state <= ERR;
                end else cnt <= cnt + 1'b1;
                SETTLE: if (cnt == S_LAST) begin
                    fcnt  <= '0;
                    state <= COUNT;
                end else cnt <= cnt + 1'b1;
                COUNT: if (trig_edge) begin
                    frame_valid <= 1'b1;
                    if (fcnt == frames_eff - FRAMES_W'(1)) state <= NEXT;
                    else fcnt <= fcnt + 1'b1;
                end
                NEXT: if (nxt[CODE_W] || nxt[CODE_W-1:0] > stop_l) begin
                    sweep_done <= 1'b1;
                    state      <= DONE;
                end else begin
                    dac_code  <= nxt[CODE_W-1:0];
                    dac_start <= 1'b1;
                    state     <= LOAD;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dac_sweep_sequencer.sv
// tb_dac_sweep_sequencer: randomized and directed sweeps checked against a code-list/frame-count model
`timescale 1ns/1ps
module tb_dac_sweep_sequencer;
    localparam int CW = 12, FW = 8, SET = 20, TO = 255;

    logic clk = 0, reset = 1, start = 1, abort = 0, trigger = 0, dac_busy = 0;
    logic [CW-1:0] cfg_start_code = 0, cfg_stop_code = 0, cfg_step = 0;
    logic [FW-1:0] cfg_frames = 0;
    logic dac_start, frame_valid, sweep_busy, sweep_done, error;
    logic [CW-1:0] dac_code;

    int checks = 0, failures = 0, cyc = 0;
    int got_codes[$];
    int fv_cnt = 0, done_cnt = 0, start_cnt = 0, last_start_cyc = 0;
    int fall_cyc = 0, min_gap = 1000000, busy_left = 0, trig_per = 100;
    bit dac_stuck = 0, fell = 0, trig_en = 0, man_trig = 0;

    dac_sweep_sequencer #(.CODE_W(CW), .FRAMES_W(FW), .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .trigger(trigger),
        .cfg_start_code(cfg_start_code), .cfg_stop_code(cfg_stop_code), .cfg_step(cfg_step),
        .cfg_frames(cfg_frames), .dac_busy(dac_busy), .dac_start(dac_start), .dac_code(dac_code),
        .frame_valid(frame_valid), .sweep_busy(sweep_busy), .sweep_done(sweep_done), .error(error)
    );

    // 1 MHz system clock
    always #500 clk = ~clk;

    // cycle counter for latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    // output monitor
    initial forever begin
        @(negedge clk);
        if (dac_start) begin
            got_codes.push_back(int'(dac_code));
            start_cnt++;
            last_start_cyc = cyc;
        end
        if (frame_valid) begin
            fv_cnt++;
            if (cyc - fall_cyc < min_gap) min_gap = cyc - fall_cyc;
        end
        if (sweep_done) done_cnt++;
    end

    // DAC writer model: busy for 5 clk after each load, or stuck high
    initial forever begin
        bit nb;
        @(negedge clk);
        if (dac_start) busy_left = 5;
        nb = dac_stuck || busy_left > 0;
        if (busy_left > 0) busy_left--;
        if (dac_busy && !nb) begin
            fall_cyc = cyc;
            fell = 1;
        end
        dac_busy = nb;
    end

    // trigger source: periodic asynchronous pulses, or a single on-request pulse
    initial forever begin
        if (trig_en) begin
            #($urandom_range(0, 999));
            trigger = 1;
            #3000;
            trigger = 0;
            #(trig_per * 1000 - 4000);
        end else if (man_trig) begin
            trigger = 1;
            repeat (3) @(negedge clk);
            trigger = 0;
            man_trig = 0;
        end else @(negedge clk);
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic pulse_trig();
        man_trig = 1;
        for (int i = 0; i < 10 && man_trig; i++) @(negedge clk);
    endtask

    task automatic launch(input int s, input int p, input int st, input int f);
        @(negedge clk);
        got_codes.delete();
        fv_cnt = 0;
        done_cnt = 0;
        start_cnt = 0;
        cfg_start_code = CW'(s);
        cfg_stop_code = CW'(p);
        cfg_step = CW'(st);
        cfg_frames = FW'(f);
        start = 1;
        @(negedge clk);
        start = 0;
        cfg_start_code = CW'($urandom);
        cfg_stop_code = CW'($urandom);
        cfg_step = CW'($urandom);
        cfg_frames = FW'($urandom);
    endtask

    task automatic wait_end(input int budget, output bit to);
        to = 1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt > 0 || error) begin
                to = 0;
                break;
            end
        end
    endtask

    task automatic run_sweep(input string tag, input int s, input int p, input int st, input int f);
        int exp[$];
        int se = (st == 0) ? 1 : st;
        int fe = (f == 0) ? 1 : f;
        int c = s;
        bit to;
        forever begin
            exp.push_back(c);
            if (c + se > 4095 || c + se > p) break;
            c += se;
        end
        launch(s, p, st, f);
        wait_end(20000, to);
        chk({tag, "_timeout"}, int'(to), 0);
        repeat (3) @(negedge clk);
        #1;
        chk({tag, "_ncodes"}, got_codes.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got_codes.size(); i++)
            chk($sformatf("%s_code%0d", tag, i), got_codes[i], exp[i]);
        chk({tag, "_frames"}, fv_cnt, exp.size() * fe);
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_error"}, int'(error), 0);
        chk({tag, "_busy"}, int'(sweep_busy), 0);
        chk({tag, "_hold"}, int'(dac_code), exp[exp.size()-1]);
    endtask

    initial begin
        bit to;
        int s, p, st, se, f;
        // reset state, with start held high through reset release
        @(negedge clk);
        chk("rst_init", int'({dac_start, frame_valid, sweep_busy, sweep_done, error, dac_code}), 0);
        reset = 0;
        repeat (20) @(negedge clk);
        chk("held_start_nolaunch", start_cnt, 0);
        chk("held_start_idle", int'(sweep_busy), 0);
        start = 0;
        repeat (3) @(negedge clk);

        // basic sweep and boundaries, trigger every 100 us
        trig_en = 1;
        trig_per = 100;
        run_sweep("basic", 100, 300, 100, 2);
        trig_per = 40;
        run_sweep("ovf", 4090, 4095, 4, 1);
        run_sweep("step0", 7, 7, 0, 1);
        run_sweep("rev", 500, 10, 3, 2);
        run_sweep("frames0", 20, 40, 10, 0);

        // triggers during settle are discarded
        trig_en = 0;
        repeat (10) @(negedge clk);
        fell = 0;
        launch(50, 50, 1, 1);
        for (int i = 0; i < 200 && !fell; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        pulse_trig();
        repeat (40) @(negedge clk);
        chk("settle_discard", fv_cnt, 0);
        pulse_trig();
        wait_end(200, to);
        chk("settle_timeout", int'(to), 0);
        repeat (2) @(negedge clk);
        chk("settle_frames", fv_cnt, 1);
        chk("settle_done", done_cnt, 1);

        // DAC stuck busy -> timeout error
        trig_en = 1;
        dac_stuck = 1;
        launch(5, 5, 1, 1);
        for (int i = 0; i < 600 && !error; i++) begin
            @(negedge clk);
            #1;
        end
        chk("to_error", int'(error), 1);
        chk("to_latency", int'(cyc - last_start_cyc >= TO && cyc - last_start_cyc <= TO + 2), 1);
        chk("to_busy", int'(sweep_busy), 0);
        repeat (10) @(negedge clk);
        chk("to_sticky", int'(error), 1);
        chk("to_nodone", done_cnt, 0);
        dac_stuck = 0;
        repeat (2) @(negedge clk);
        run_sweep("after_err", 1000, 1200, 100, 1);

        // abort during WAIT_DAC
        launch(10, 10, 1, 2);
        @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        #1;
        chk("ab_wait_busy", int'(sweep_busy), 0);
        repeat (300) @(negedge clk);
        chk("ab_wait_starts", start_cnt, 1);
        chk("ab_wait_frames", fv_cnt, 0);
        chk("ab_wait_done", done_cnt, 0);

        // abort during COUNT
        launch(30, 60, 10, 3);
        for (int i = 0; i < 3000 && fv_cnt == 0; i++) @(negedge clk);
        abort = 1;
        @(negedge clk);
        abort = 0;
        #1;
        chk("ab_cnt_busy", int'(sweep_busy), 0);
        repeat (300) @(negedge clk);
        chk("ab_cnt_frames", fv_cnt, 1);
        chk("ab_cnt_starts", start_cnt, 1);
        chk("ab_cnt_done", done_cnt, 0);

        // reset mid-COUNT, then a fresh sweep
        launch(77, 77, 1, 3);
        for (int i = 0; i < 3000 && fv_cnt == 0; i++) @(negedge clk);
        #200;
        reset = 1;
        #1;
        chk("rst_mid", int'({dac_start, frame_valid, sweep_busy, sweep_done, error, dac_code}), 0);
        repeat (3) @(negedge clk);
        reset = 0;
        repeat (3) @(negedge clk);
        run_sweep("post_rst", 200, 260, 30, 2);

        // randomized sweeps
        for (int k = 0; k < 10; k++) begin
            trig_per = $urandom_range(30, 60);
            s = $urandom_range(0, 4095);
            st = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 1500);
            se = (st == 0) ? 1 : st;
            if ($urandom_range(0, 4) == 0) p = $urandom_range(0, s);
            else p = s + se * $urandom_range(0, 3) + $urandom_range(0, se - 1);
            if (p > 4095) p = 4095;
            f = $urandom_range(0, 3);
            run_sweep($sformatf("rnd%0d", k), s, p, st, f);
        end

        chk("settle_gap", int'(min_gap >= SET), 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
